pixel_write_sink: RTL and testbench

Receiving end of the paddle/ball drawing interface: accepts pixel-plot strobes (x, y, colour, plot) from the drawing datapaths and turns them into framebuffer memory writes. Incoming pixels are buffered in a small FIFO so the drawer is never stalled by scan-out arbitration on the framebuffer port. Linear addresses are computed as y*320 + x, and memory back-pressure is handled. The block sits between the drawing control/datapath pair and the framebuffer RAM.

---
 rtl/pong_gfx_pkg.sv | 17 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/pixel_write_sink.sv | 80 ++++++++
 tb/tb_pixel_write_sink.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pong_gfx_pkg.sv
// pong_gfx_pkg: shared screen geometry, pixel types and sink FSM states
package pong_gfx_pkg;
  localparam logic [8:0] SCREEN_W = 9'd320;
  localparam logic [7:0] SCREEN_H = 8'd240;
  localparam int ADDR_W = 17;
  typedef logic [2:0] colour_t;
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    colour_t colour;
  } pixel_t;
  typedef enum logic {IDLE, WRITE} sink_state_t;
  // y*320 + x using shifts; the widest raw result still fits in ADDR_W bits
  function automatic logic [ADDR_W-1:0] pixel_addr(logic [8:0] x, logic [7:0] y);
    return ({9'b0, y} << 8) + ({9'b0, y} << 6) + {8'b0, x};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy level; push into full and pop from empty are ignored
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign level = level_q;
  assign dout = mem_q[rd_q];
  // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset: empty pointers make stale contents unreachable
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/pixel_write_sink.sv
// pixel_write_sink: buffers plotted pixels and issues framebuffer writes; optional CLIP_EN drops and counts off-screen pixels
module pixel_write_sink
  import pong_gfx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          plot,
  input  logic [8:0]                    x,
  input  logic [7:0]                    y,
  input  logic [2:0]                    colour,
  output logic                          ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [2:0]                    mem_data,
  input  logic                          mem_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   clip_count,
  input  logic                          clear
);
  sink_state_t state_q, state_d;
  pixel_t in_px, head_px;
  logic [ADDR_W-1:0] addr_q, addr_d;
  colour_t data_q, data_d;
  logic full, empty, clip, push, pop, drop, issue, ovf_q;
  assign in_px = '{x: x, y: y, colour: colour};
  assign push = plot && !clip && !full;
  assign drop = plot && !clip && full;
  assign ready = !full;
  assign mem_we = state_q == WRITE;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign overflow = ovf_q;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(pixel_t))) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .pop(pop), .din(in_px),
    .dout(head_px), .level(fifo_level), .full(full), .empty(empty)
  );

`ifdef CLIP_EN
  logic [15:0] clip_q;
  assign clip = plot && (x >= SCREEN_W || y >= SCREEN_H);
  assign clip_count = clip_q;
  // saturating clip counter; a clip in the same cycle as clear restarts at 1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) clip_q <= '0;
    else if (clip) clip_q <= clear ? 16'd1 : (clip_q == 16'hFFFF ? clip_q : clip_q + 16'd1);
    else if (clear) clip_q <= '0;
  end
`else
  assign clip = 1'b0;
  assign clip_count = '0;
`endif

  // output FSM: IDLE always loads a waiting pixel; WRITE advances only once the port is free
  always_comb begin
    issue = state_q == IDLE || !mem_busy;
    pop = issue && !empty;
    state_d = issue ? (empty ? IDLE : WRITE) : state_q;
    addr_d = pop ? pixel_addr(head_px.x, head_px.y) : addr_q;
    data_d = pop ? head_px.colour : data_q;
  end

  // state, held write address/colour and sticky overflow (a drop beats clear)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ovf_q <= drop ? 1'b1 : (clear ? 1'b0 : ovf_q);
    end
  end
endmodule

// File: tb/tb_pixel_write_sink.sv
// tb_pixel_write_sink: directed self-checking bench for pixel_write_sink
module tb_pixel_write_sink;
  logic clk = 1'b0;
  logic resetn, plot, mem_busy, clear;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic ready, mem_we, overflow;
  logic [16:0] mem_addr;
  logic [2:0] mem_data;
  logic [3:0] fifo_level;
  logic [15:0] clip_count;
  int checks = 0;
  int errors = 0;
  logic [19:0] wq [$];

  pixel_write_sink #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
    .ready(ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_busy(mem_busy), .fifo_level(fifo_level), .overflow(overflow),
    .clip_count(clip_count), .clear(clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetn && mem_we && !mem_busy) wq.push_back({mem_addr, mem_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    resetn = 0; plot = 0; x = 0; y = 0; colour = 0; mem_busy = 0; clear = 0;
    tick(); tick();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_clip", clip_count, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", ready, 1);
    resetn = 1;
    tick();

    // single pixel, latency and address
    wq.delete();
    plot = 1; x = 10; y = 5; colour = 3'b101;
    tick();
    plot = 0;
    chk("t1_level", fifo_level, 1);
    chk("t1_we0", mem_we, 0);
    tick();
    chk("t1_we1", mem_we, 1);
    chk("t1_addr", mem_addr, 1610);
    chk("t1_data", mem_data, 5);
    tick();
    chk("t1_we_end", mem_we, 0);
    chk("t1_nwrites", wq.size(), 1);

    // fill under busy: one pixel parks in the output register, eight fill the FIFO, tenth dropped
    wq.delete();
    mem_busy = 1;
    for (int i = 1; i <= 10; i++) begin
      plot = 1; x = 9'(i); y = 8'(i); colour = 3'(i);
      tick();
      if (i == 9) begin
        chk("t2_ready_full", ready, 0);
        chk("t2_level_full", fifo_level, 8);
        chk("t2_ovf_before", overflow, 0);
      end
    end
    plot = 0;
    chk("t2_ovf", overflow, 1);
    chk("t2_level", fifo_level, 8);
    chk("t2_addr_held", mem_addr, 321);
    mem_busy = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_stream_we", mem_we, 1);
      chk("t2_stream_addr", mem_addr, (k + 2) * 321);
    end
    tick();
    chk("t2_we_end", mem_we, 0);
    chk("t2_nwrites", wq.size(), 9);
    for (int k = 0; k < 9 && k < wq.size(); k++)
      chk("t2_order", wq[k], {17'((k + 1) * 321), 3'(k + 1)});

    // overflow clear
    clear = 1;
    tick();
    clear = 0;
    chk("clr_ovf", overflow, 0);

    // busy toggling 1,0,1,0
    wq.delete();
    mem_busy = 1;
    plot = 1; x = 100; y = 50; colour = 2;
    tick();
    x = 7; y = 200; colour = 6;
    tick();
    plot = 0;
    chk("t3_addrA", mem_addr, 16100);
    chk("t3_dataA", mem_data, 2);
    mem_busy = 0;
    tick();
    chk("t3_addrB", mem_addr, 64007);
    chk("t3_dataB", mem_data, 6);
    mem_busy = 1;
    tick();
    chk("t3_holdB_we", mem_we, 1);
    chk("t3_holdB_addr", mem_addr, 64007);
    chk("t3_holdB_data", mem_data, 6);
    mem_busy = 0;
    tick();
    chk("t3_we_end", mem_we, 0);
    chk("t3_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t3_w0", wq[0], {17'd16100, 3'd2});
      chk("t3_w1", wq[1], {17'd64007, 3'd6});
    end

    // corner pixel
    plot = 1; x = 319; y = 239; colour = 7;
    tick();
    plot = 0;
    tick();
    chk("corner_addr", mem_addr, 76799);
    chk("corner_data", mem_data, 7);
    tick();

`ifdef CLIP_EN
    wq.delete();
    plot = 1; x = 320; y = 0; colour = 1;
    tick();
    x = 0; y = 240;
    tick();
    plot = 0;
    chk("clip_cnt2", clip_count, 2);
    tick(); tick();
    chk("clip_nwrites", wq.size(), 0);
    chk("clip_we", mem_we, 0);
    clear = 1; plot = 1; x = 400; y = 10;
    tick();
    clear = 0; plot = 0;
    chk("clip_clear_wins", clip_count, 1);
    chk("clip_no_ovf", overflow, 0);
`else
    plot = 1; x = 320; y = 0; colour = 1;
    tick();
    plot = 0;
    tick();
    chk("noclip_addr", mem_addr, 320);
    chk("noclip_we", mem_we, 1);
    chk("noclip_cnt", clip_count, 0);
    tick();
`endif

    // reset mid-write with three queued entries
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      plot = 1; x = 9'(20 + i); y = 8'(i); colour = 3'(i);
      tick();
    end
    plot = 0;
    chk("t6_we", mem_we, 1);
    chk("t6_level", fifo_level, 3);
    resetn = 0;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_ready", ready, 1);
    mem_busy = 0;
    wq.delete();
    tick();
    resetn = 1;
    tick(); tick(); tick();
    chk("t6_no_stale", wq.size(), 0);
    chk("t6_we_idle", mem_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
